vga_scan_controller: RTL and testbench
======================================

# vga_scan_controller

Generates 640x480 at 60 Hz VGA raster timing from the 50 MHz system clock. It drives the DrawX/DrawY pixel coordinates consumed by the colour mapper and accepts that mapper's combinational Red/Green/Blue back in the same pixel slot. It outputs registered, mutually aligned sync, blank, pixel-clock and colour signals to the board DAC, plus a once-per-frame tick used to advance game state.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

- Clk  in  1  50 MHz system clock; the only clock
- Reset  in  1  asynchronous, active-high
- Red_in, Green_in, Blue_in  in  8 each  colour for current DrawX/DrawY, from the colour mapper
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- VGA_CLK  out  1  25 MHz pixel clock to DAC
- VGA_HS  out  1  horizontal sync, active-low
- VGA_VS  out  1  vertical sync, active-low
- VGA_BLANK_N  out  1  high during visible region
- VGA_SYNC_N  out  1  tied 0
- VGA_R, VGA_G, VGA_B  out  8 each  colour to DAC
- Frame_Tick  out  1  one-Clk pulse per frame at start of vertical blank

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must be ≤1024 so they fit 10-bit counters.
- pix_en is a 1-bit toggle register that flips every Clk. All counter and output-register updates occur only on Clk edges where pix_en=1.
- hc counter: on an update, if hc=H_TOTAL-1 it goes to 0; otherwise it increments.
- vc counter: increments only when hc wraps. If vc=V_TOTAL-1 at that point, it goes to 0.
- DrawX=hc and DrawY=vc, driven directly from the counter registers with no extra delay. The colour mapper is combinational, so Red_in/Green_in/Blue_in are valid for the same hc/vc.
- Output register stage, loaded on update edges from the current hc/vc:
  - VGA_HS = 0 iff H_VISIBLE+H_FP ≤ hc < H_VISIBLE+H_FP+H_SYNC (656..751)
  - VGA_VS = 0 iff V_VISIBLE+V_FP ≤ vc < V_VISIBLE+V_FP+V_SYNC (490..491)
  - VGA_BLANK_N = (hc < H_VISIBLE) && (vc < V_VISIBLE)
  - VGA_R/G/B = *_in when that blank term is 1, else 0
- Frame_Tick is a register set for exactly one Clk after the update edge where hc=H_TOTAL-1 and vc=V_VISIBLE-1. It is 0 at all other times.
- VGA_CLK = pix_en register. Output registers change on the edge where VGA_CLK falls, so data is stable at the VGA_CLK rising edge.
- Reset values, applied immediately and asynchronously:
  - pix_en=0, hc=0, vc=0
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0
  - VGA_R/G/B=0, Frame_Tick=0
  - VGA_SYNC_N=0 at all times
- Reset mid-frame abandons the frame. The first update after release occurs on the second Clk edge, because pix_en must be 1.

## Timing
- Pixel period: 2 Clk. Line: 1600 Clk. Frame: 840000 Clk.
- Latency: DAC-facing outputs lag DrawX/DrawY by exactly one pixel (2 Clk). HS, VS, BLANK_N and RGB are mutually aligned with zero skew.
- Sync pulse widths: HS low for 96 pixels (192 Clk). VS low for 2 lines (3200 Clk).
- Simultaneous events: an hc wrap and a vc wrap in the same update both take effect. After (799,524), the next pixel is (0,0).
- Red_in/Green_in/Blue_in are sampled only on update edges. Changes between update edges are ignored.

## Test plan
- Reset asserted mid-line, asynchronous to Clk → with no clock edge, DrawX=0, DrawY=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R=0, Frame_Tick=0.
- Free run after reset release → DrawX steps 0,1,2… every 2 Clk. After DrawX=799, it returns to 0 with DrawY=1. Line period is measured at 1600 Clk.
- Horizontal sync → VGA_HS falls 2 Clk after DrawX becomes 656 and stays low exactly 192 Clk. VGA_BLANK_N falls 2 Clk after DrawX becomes 640.
- Vertical/frame → VGA_VS is low for exactly 3200 Clk, starting one pixel after DrawY becomes 490. Frame_Tick is high for exactly 1 Clk every 840000 Clk, 2 Clk after (799,479).
- Colour gating with Red_in=8'hff, Green_in=8'h44, Blue_in=8'h00 held → VGA_R=ff and VGA_G=44 only while VGA_BLANK_N=1. All channels are 0 for DrawX 640..799 (delayed one pixel) and for lines 480..524.
- Wrap corner → at DrawX=799, DrawY=524, the next update gives DrawX=0, DrawY=0, and VGA_BLANK_N=1 one pixel later.

Source files
------------

// File: rtl/vga_scan_controller.sv
// VGA raster timing generator: pixel-rate enable, h/v scan counters and a
// registered DAC-facing output stage aligned one pixel behind DrawX/DrawY.
`timescale 1ns/1ps
module vga_scan_controller #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       Frame_Tick
);

  // Totals must stay <= 1024 so the 10-bit counters can hold them.
  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HMax        = 10'(HTotal - 1);
  localparam logic [9:0] VMax        = 10'(VTotal - 1);
  localparam logic [9:0] HVis        = 10'(H_VISIBLE);
  localparam logic [9:0] VVis        = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncStart  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HSyncEnd    = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VSyncEnd    = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] VLastVis    = 10'(V_VISIBLE - 1);

  logic       pix_en_q, pix_en_d;
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_n_q, blank_n_d;
  logic [7:0] r_q, r_d;
  logic [7:0] g_q, g_d;
  logic [7:0] b_q, b_d;
  logic       tick_q, tick_d;
  logic       update;
  logic       visible;

  // Next-state: counters and output stage advance only on pixel-enable edges.
  always_comb begin
    update    = pix_en_q;
    pix_en_d  = ~pix_en_q;
    hc_d      = hc_q;
    vc_d      = vc_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    visible   = (hc_q < HVis) && (vc_q < VVis);

    if (update) begin
      if (hc_q == HMax) begin
        hc_d = 10'd0;
        vc_d = (vc_q == VMax) ? 10'd0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
      // Output stage samples the current pixel, so it lags DrawX/DrawY by one pixel.
      hs_d      = !((hc_q >= HSyncStart) && (hc_q < HSyncEnd));
      vs_d      = !((vc_q >= VSyncStart) && (vc_q < VSyncEnd));
      blank_n_d = visible;
      r_d       = visible ? Red_in   : 8'h00;
      g_d       = visible ? Green_in : 8'h00;
      b_d       = visible ? Blue_in  : 8'h00;
    end

    // Single-Clk pulse when the last visible line finishes.
    tick_d = update && (hc_q == HMax) && (vc_q == VLastVis);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_en_q  <= 1'b0;
      hc_q      <= 10'd0;
      vc_q      <= 10'd0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= 8'h00;
      g_q       <= 8'h00;
      b_q       <= 8'h00;
      tick_q    <= 1'b0;
    end else begin
      pix_en_q  <= pix_en_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      tick_q    <= tick_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  // Update edges are where pix_en falls, so DAC data is stable on VGA_CLK rise.
  assign VGA_CLK     = pix_en_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign Frame_Tick  = tick_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller. Horizontal timing is the default 800-pixel
// line; vertical timing is shortened (4 visible + 2 + 2 + 2 = 10 lines) so that
// more than one full frame fits in a short run. Expected signal transitions are
// queued with their Clk edge number (edges counted from reset release); a
// monitor pops and compares whenever a DUT output changes.
`timescale 1ns/1ps
module tb_vga_scan_controller;

  localparam int End = 23000;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Red_in = 8'hff;
  logic [7:0] Green_in = 8'h44;
  logic [7:0] Blue_in = 8'h00;
  logic [9:0] DrawX, DrawY;
  logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, Frame_Tick;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  vga_scan_controller #(
    .V_VISIBLE(4),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Red_in     (Red_in),
    .Green_in   (Green_in),
    .Blue_in    (Blue_in),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .VGA_CLK    (VGA_CLK),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N (VGA_SYNC_N),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .Frame_Tick (Frame_Tick)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    int val;
    int cyc;
  } ev_t;

  // 0 DrawX, 1 DrawY, 2 BLANK_N, 3 HS, 4 VS, 5 Frame_Tick
  ev_t   q[6][$];
  string names[6] = '{"drawx", "drawy", "blank_n", "hs", "vs", "frame_tick"};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  logic mon_en = 1'b0;

  logic [9:0] px, py;
  logic       pb, ph, pv, pt;

  // Clk edges since reset release.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Colour mapper stand-in: correct value only ahead of update edges, junk otherwise.
  always @(negedge Clk) begin
    Red_in <= (cyc % 2 == 1) ? 8'hff : 8'h11;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int val, input int c);
    ev_t e;
    e.val = val;
    e.cyc = c;
    if (c < End) q[k].push_back(e);
  endtask

  task automatic pop_check(input int k, input int val);
    ev_t e;
    n_tests++;
    if (q[k].size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected change to %0d at edge %0d", names[k], val, cyc);
    end else begin
      e = q[k].pop_front();
      if (e.val != val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: got %0d at edge %0d, expected %0d at edge %0d",
                 names[k], val, cyc, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: any output change must match the head of its queue.
  always @(negedge Clk) begin
    if (mon_en) begin
      if (DrawX != px)        pop_check(0, int'(DrawX));
      if (DrawY != py)        pop_check(1, int'(DrawY));
      if (VGA_BLANK_N != pb)  pop_check(2, int'(VGA_BLANK_N));
      if (VGA_HS != ph)       pop_check(3, int'(VGA_HS));
      if (VGA_VS != pv)       pop_check(4, int'(VGA_VS));
      if (Frame_Tick != pt)   pop_check(5, int'(Frame_Tick));
      check("rgb_gate", int'({VGA_R, VGA_G, VGA_B}),
            VGA_BLANK_N ? 32'hff4400 : 32'h0);
    end
    px <= DrawX;
    py <= DrawY;
    pb <= VGA_BLANK_N;
    ph <= VGA_HS;
    pv <= VGA_VS;
    pt <= Frame_Tick;
  end

  initial begin
    // Expected transitions, as Clk edge numbers after release. DrawX becomes
    // pixel P at edge 2P; outputs for pixel P load at edge 2P+2.
    for (int k = 1; 2 * k < End; k++) push(0, k % 800, 2 * k);
    for (int l = 1; 1600 * l < End; l++) push(1, l % 10, 1600 * l);
    for (int l = 0; 1600 * l < End; l++) begin
      if (l % 10 < 4) begin
        push(2, 1, 1600 * l + 2);
        push(2, 0, 1600 * l + 1282);
      end
      push(3, 0, 1600 * l + 1314);
      push(3, 1, 1600 * l + 1506);
    end
    for (int f = 0; 16000 * f < End; f++) begin
      push(4, 0, 16000 * f + 9602);
      push(4, 1, 16000 * f + 12802);
      push(5, 1, 16000 * f + 6400);
      push(5, 0, 16000 * f + 6401);
    end

    // Run into the middle of a line, then reset between clock edges.
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (1000) @(negedge Clk);
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    check("rst_drawx", int'(DrawX), 0);
    check("rst_drawy", int'(DrawY), 0);
    check("rst_hs", int'(VGA_HS), 1);
    check("rst_vs", int'(VGA_VS), 1);
    check("rst_blank_n", int'(VGA_BLANK_N), 0);
    check("rst_r", int'(VGA_R), 0);
    check("rst_g", int'(VGA_G), 0);
    check("rst_tick", int'(Frame_Tick), 0);
    check("rst_vga_clk", int'(VGA_CLK), 0);
    check("sync_n", int'(VGA_SYNC_N), 0);

    repeat (3) @(negedge Clk);
    Reset  = 1'b0;
    mon_en = 1'b1;
    while (cyc < End) @(negedge Clk);
    mon_en = 1'b0;

    for (int k = 0; k < 6; k++) begin
      while (q[k].size() > 0) begin
        ev_t e;
        e = q[k].pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL %s: no change seen, expected %0d at edge %0d", names[k], e.val, e.cyc);
      end
    end
    check("sync_n_end", int'(VGA_SYNC_N), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
